// File: rtl/hilo_muldiv_unit.sv
// HI/LO register stage behind the EX ALU: captures multiply results, handles MTHI/MTLO,
// and runs a 1-bit-per-cycle restoring divider that writes quotient to LO and remainder to HI.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              op_valid_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [DATA_W-1:0] alu_lo_i,
  input  logic [DATA_W-1:0] alu_hi_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              div_zero_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] dvd_q, dvs_q, rem_q;
  logic              sx_q, sy_q;
  logic              busy_q, done_q, div_zero_q;

  logic              x_neg, y_neg;
  logic [DATA_W-1:0] x_abs, y_abs;
  logic [DATA_W:0]   rem_shift, rem_diff;
  logic              q_bit;
  logic [DATA_W-1:0] rem_d, dvd_d;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  // Signed divides run on magnitudes; the signs are restored in FIX.
  assign x_neg = (op_i == OP_DIV) && x_i[DATA_W-1];
  assign y_neg = (op_i == OP_DIV) && y_i[DATA_W-1];
  assign x_abs = x_neg ? -x_i : x_i;
  assign y_abs = y_neg ? -y_i : y_i;

  // The dividend register shifts out its msb and shifts in quotient bits, ending as the quotient.
  assign rem_shift = {rem_q, dvd_q[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~rem_diff[DATA_W];
  assign rem_d     = q_bit ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
  assign dvd_d     = {dvd_q[DATA_W-2:0], q_bit};

  assign quo_fix = (sx_q ^ sy_q) ? -dvd_q : dvd_q;
  assign rem_fix = sx_q ? -rem_q : rem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (op_valid_i) begin
            case (op_i)
              OP_MULT: begin
                hi_q <= alu_hi_i;
                lo_q <= alu_lo_i;
              end
              OP_MTHI: hi_q <= x_i;
              OP_MTLO: lo_q <= x_i;
              OP_DIV, OP_DIVU: begin
                dvd_q      <= x_abs;
                dvs_q      <= y_abs;
                sx_q       <= x_neg;
                sy_q       <= y_neg;
                div_zero_q <= (y_i == '0);
                rem_q      <= '0;
                cnt_q      <= CNT_W'(DATA_W - 1);
                busy_q     <= 1'b1;
                state_q    <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          lo_q    <= quo_fix;
          hi_q    <= rem_fix;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: a reference model predicts HI/LO/div_zero into a
// scoreboard queue at issue time, and entries are popped when the DUT writes its result.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic         clk, rst_n, op_valid;
  logic [2:0]   op;
  logic [W-1:0] x, y, alu_lo, alu_hi;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sbQ[$];
  logic [W-1:0] hiM, loM;
  logic         dzM;
  bit           divPending;
  int           cyc, acceptCycle;
  int           testCount, failCount;

  hilo_muldiv_unit #(.DATA_W(W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .op_valid_i(op_valid),
    .op_i      (op),
    .x_i       (x),
    .y_i       (y),
    .alu_lo_i  (alu_lo),
    .alu_hi_i  (alu_hi),
    .busy_o    (busy),
    .done_o    (done),
    .div_zero_o(div_zero),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    testCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Architectural divide result, written from the ISA's point of view rather than the datapath.
  task automatic divModel(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = (sgn && a[W-1]) ? 32'd1 : '1;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic predict(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ah, input logic [W-1:0] al, input string tag);
    exp_t         e;
    bit           push;
    logic [W-1:0] q, r;
    push = 1'b1;
    case (o)
      OP_MULT: begin hiM = ah; loM = al; end
      OP_MTHI: hiM = a;
      OP_MTLO: loM = a;
      OP_DIV, OP_DIVU: begin
        divModel(o == OP_DIV, a, b, q, r);
        loM = q;
        hiM = r;
        dzM = (b == '0);
        divPending = 1'b1;
      end
      default: push = 1'b0;
    endcase
    if (push) begin
      e.tag = tag; e.hi = hiM; e.lo = loM; e.dz = dzM;
      sbQ.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the edge that samples the op.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] ah, input logic [W-1:0] al, input string tag);
    bit startsDiv;
    startsDiv = !divPending && (o == OP_DIV || o == OP_DIVU);
    op = o; x = a; y = b; alu_hi = ah; alu_lo = al; op_valid = 1'b1;
    if (!divPending) predict(o, a, b, ah, al, tag);
    @(negedge clk);
    op_valid = 1'b0;
    if (startsDiv) acceptCycle = cyc;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    testCount++;
    assert (sbQ.size() != 0) else begin
      failCount++;
      $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_lo"}, lo, e.lo);
      chk({tag, "_dz"}, W'(div_zero), W'(e.dz));
    end
  endtask

  // Waits (bounded) for busy to fall, then checks latency, done and the popped result.
  task automatic waitDone(input string tag);
    while (busy && (cyc - acceptCycle) < 100) @(negedge clk);
    divPending = 1'b0;
    chk({tag, "_latency"}, W'(cyc - acceptCycle), W'(W + 1));
    chk({tag, "_done"}, W'(done), 32'd1);
    checkOutput(tag);
  endtask

  initial begin
    testCount = 0; failCount = 0; cyc = 0; acceptCycle = 0;
    hiM = '0; loM = '0; dzM = 1'b0; divPending = 1'b0;
    rst_n = 1'b0; op_valid = 1'b0; op = OP_NOP;
    x = '0; y = '0; alu_lo = '0; alu_hi = '0;

    #12;
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_dz", W'(div_zero), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(OP_MULT, '0, '0, 32'h0000_0001, 32'h0000_0002, "mult");
    chk("mult_busy", W'(busy), '0);
    checkOutput("mult");

    applyStimulus(3'b111, 32'h1234_5678, '0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rsvd");
    chk("rsvd_hi", hi, hiM);
    chk("rsvd_lo", lo, loM);

    applyStimulus(OP_DIVU, 32'd100, 32'd7, '0, '0, "divu100_7");
    chk("divu100_7_busy", W'(busy), 32'd1);
    waitDone("divu100_7");
    @(negedge clk);
    chk("divu100_7_done_once", W'(done), '0);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0, "div_m7_2");
    waitDone("div_m7_2");

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, "div_ovf");
    waitDone("div_ovf");

    applyStimulus(OP_DIVU, 32'd5, 32'd0, '0, '0, "divu5_0");
    waitDone("divu5_0");

    applyStimulus(OP_DIV, 32'hFFFF_FFF3, 32'd0, '0, '0, "div_m13_0");
    waitDone("div_m13_0");

    applyStimulus(OP_DIVU, 32'd1000, 32'd3, '0, '0, "divu_abort");
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_before", W'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sbQ.delete();
    hiM = '0; loM = '0; dzM = 1'b0; divPending = 1'b0;
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    chk("abort_busy", W'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(OP_DIVU, 32'd9, 32'd3, '0, '0, "divu9_3");
    waitDone("divu9_3");

    applyStimulus(OP_DIVU, 32'd100, 32'd7, '0, '0, "divu_hold");
    applyStimulus(OP_MTHI, 32'hA5A5_A5A5, '0, '0, '0, "mthi_busy");
    applyStimulus(OP_MULT, '0, '0, 32'h1111_1111, 32'h2222_2222, "mult_busy_ign");
    applyStimulus(OP_MTLO, 32'h5A5A_5A5A, '0, '0, '0, "mtlo_busy");
    waitDone("divu_hold");

    applyStimulus(OP_MTHI, 32'hA5A5_A5A5, '0, '0, '0, "mthi_after");
    chk("mthi_after_done_once", W'(done), '0);
    checkOutput("mthi_after");

    applyStimulus(OP_MTLO, 32'h0BAD_F00D, '0, '0, '0, "mtlo");
    checkOutput("mtlo");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
